// File: rtl/spwm_pkg.sv
// spwm_pkg: shared leg state encoding and dead-time defaults
package spwm_pkg;
    localparam int DT_W_DEF = 8;
    localparam int DT_MIN_DEF = 1;
    localparam int IDLE_BIT = 0;
    localparam int DEAD_BIT = 1;
    localparam int HI_BIT = 2;
    localparam int LO_BIT = 3;
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        DEAD  = 4'b0010,
        HI_ON = 4'b0100,
        LO_ON = 4'b1000
    } leg_state_t;
endpackage

// File: rtl/spwm_deadtime_leg.sv
// deadtime_leg: one half-bridge leg with input register, dead counter and one-hot FSM
module deadtime_leg
    import spwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            fault,
    input  logic [DT_W-1:0] d,
    input  logic            spwm,
    output logic            hi,
    output logic            lo,
    output logic            busy
);
    leg_state_t state;
    logic in_q;
    logic [DT_W-1:0] cnt;

    // gates come straight from state flops so they cannot glitch
    assign hi = state[HI_BIT];
    assign lo = state[LO_BIT];
    assign busy = ~state[IDLE_BIT];

    // every switch passes through a full dead interval; disable/fault wins over everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q <= 1'b0;
            state <= IDLE;
            cnt <= '0;
        end else begin
            in_q <= spwm;
            if (!en || fault) begin
                state <= IDLE;
                cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= DEAD;
                        cnt <= d;
                    end
                    HI_ON: if (!in_q) begin
                        state <= DEAD;
                        cnt <= d;
                    end
                    LO_ON: if (in_q) begin
                        state <= DEAD;
                        cnt <= d;
                    end
                    DEAD: begin
                        cnt <= cnt - DT_W'(1);
                        if (cnt == DT_W'(1)) state <= in_q ? HI_ON : LO_ON;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/spwm_deadtime.sv
// spwm_deadtime: H-bridge gate drive with dead time, latched fault and enable
module spwm_deadtime
    import spwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEF,
    parameter int DT_MIN = DT_MIN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [DT_W-1:0] dead_time,
    input  logic            spwm_a,
    input  logic            spwm_b,
    input  logic            fault_in,
    input  logic            fault_clr,
    output logic            a_hi,
    output logic            a_lo,
    output logic            b_hi,
    output logic            b_lo,
    output logic            fault,
    output logic            active
);
    logic [DT_W-1:0] d;
    logic a_busy, b_busy;

    assign d = (dead_time < DT_W'(DT_MIN)) ? DT_W'(DT_MIN) : dead_time;

    deadtime_leg #(.DT_W(DT_W)) u_leg_a (
        .clk(clk), .rst(rst), .en(en), .fault(fault), .d(d), .spwm(spwm_a),
        .hi(a_hi), .lo(a_lo), .busy(a_busy)
    );

    deadtime_leg #(.DT_W(DT_W)) u_leg_b (
        .clk(clk), .rst(rst), .en(en), .fault(fault), .d(d), .spwm(spwm_b),
        .hi(b_hi), .lo(b_lo), .busy(b_busy)
    );

    // sticky fault: a clear request loses to a fault still present
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault <= 1'b0;
            active <= 1'b0;
        end else begin
            fault <= fault_in | (fault & ~fault_clr);
            active <= a_busy | b_busy;
        end
    end

    shoot_through: assert property (@(posedge clk) !(a_hi && a_lo) && !(b_hi && b_lo));
endmodule

// File: tb/tb_spwm_deadtime.sv
// tb_spwm_deadtime: directed checks of dead time, glitch absorption, fault and reset
module tb_spwm_deadtime;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic [7:0] dead_time = 8'd0;
    logic spwm_a = 1'b0;
    logic spwm_b = 1'b0;
    logic fault_in = 1'b0;
    logic fault_clr = 1'b0;
    logic a_hi, a_lo, b_hi, b_lo, fault, active;
    int total = 0;
    int bad = 0;

    spwm_deadtime dut (
        .clk(clk), .rst(rst), .en(en), .dead_time(dead_time),
        .spwm_a(spwm_a), .spwm_b(spwm_b), .fault_in(fault_in), .fault_clr(fault_clr),
        .a_hi(a_hi), .a_lo(a_lo), .b_hi(b_hi), .b_lo(b_lo),
        .fault(fault), .active(active)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if ((a_hi && a_lo) || (b_hi && b_lo)) begin
            bad++;
            $display("FAIL overlap at %0t: a=%b%b b=%b%b", $time, a_hi, a_lo, b_hi, b_lo);
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if ({a_hi, a_lo, b_hi, b_lo, fault, active} !== 6'b0) begin
            bad++;
            $display("FAIL reset: got %b want 000000", {a_hi, a_lo, b_hi, b_lo, fault, active});
        end
        rst = 1'b0;
    endtask

    task automatic test_startup();
        en = 1'b1;
        spwm_a = 1'b1;
        dead_time = 8'd4;
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if ({a_hi, a_lo, b_hi, b_lo} !== ((i == 5) ? 4'b1001 : 4'b0000)) begin
                bad++;
                $display("FAIL startup cycle %0d: gates %b want %b", i, {a_hi, a_lo, b_hi, b_lo},
                         (i == 5) ? 4'b1001 : 4'b0000);
            end
        end
        total++;
        if (active !== 1'b1) begin
            bad++;
            $display("FAIL startup active: got %b want 1", active);
        end
    endtask

    task automatic test_fall();
        spwm_a = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            total++;
            if ({a_hi, a_lo} !== {i < 2, i == 6}) begin
                bad++;
                $display("FAIL fall cycle %0d: a %b want %b", i, {a_hi, a_lo}, {i < 2, i == 6});
            end
        end
    endtask

    task automatic test_min_dead();
        dead_time = 8'd0;
        spwm_a = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if ({a_hi, a_lo} !== {i == 3, i == 1}) begin
                bad++;
                $display("FAIL min_dead rise %0d: a %b want %b", i, {a_hi, a_lo}, {i == 3, i == 1});
            end
        end
        spwm_a = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if ({a_hi, a_lo} !== {i == 1, i == 3}) begin
                bad++;
                $display("FAIL min_dead fall %0d: a %b want %b", i, {a_hi, a_lo}, {i == 1, i == 3});
            end
        end
    endtask

    task automatic test_glitch();
        dead_time = 8'd1;
        spwm_b = 1'b1;
        repeat (4) tick();
        total++;
        if ({b_hi, b_lo} !== 2'b10) begin
            bad++;
            $display("FAIL glitch setup: b %b want 10", {b_hi, b_lo});
        end
        dead_time = 8'd8;
        spwm_b = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if ({b_hi, b_lo, a_lo} !== {i < 2 || i == 10, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL glitch cycle %0d: b %b a_lo %b want %b", i, {b_hi, b_lo}, a_lo,
                         {i < 2 || i == 10, 1'b0, 1'b1});
            end
            if (i == 2) spwm_b = 1'b1;
        end
    endtask

    task automatic test_fault();
        dead_time = 8'd3;
        fault_in = 1'b1;
        tick();
        total++;
        if ({a_hi, a_lo, b_hi, b_lo, fault} !== 5'b01101) begin
            bad++;
            $display("FAIL fault latch: got %b want 01101", {a_hi, a_lo, b_hi, b_lo, fault});
        end
        fault_in = 1'b0;
        tick();
        total++;
        if ({a_hi, a_lo, b_hi, b_lo, fault, active} !== 6'b000011) begin
            bad++;
            $display("FAIL fault off: got %b want 000011", {a_hi, a_lo, b_hi, b_lo, fault, active});
        end
        tick();
        total++;
        if ({a_hi, a_lo, b_hi, b_lo, fault, active} !== 6'b000010) begin
            bad++;
            $display("FAIL fault idle: got %b want 000010", {a_hi, a_lo, b_hi, b_lo, fault, active});
        end
    endtask

    task automatic test_fault_clr();
        fault_in = 1'b1;
        fault_clr = 1'b1;
        tick();
        total++;
        if (fault !== 1'b1) begin
            bad++;
            $display("FAIL clr_with_fault: fault %b want 1", fault);
        end
        fault_in = 1'b0;
        fault_clr = 1'b0;
        tick();
        total++;
        if ({a_hi, a_lo, b_hi, b_lo, fault} !== 5'b00001) begin
            bad++;
            $display("FAIL fault_hold: got %b want 00001", {a_hi, a_lo, b_hi, b_lo, fault});
        end
        fault_clr = 1'b1;
        tick();
        total++;
        if ({a_hi, a_lo, b_hi, b_lo, fault} !== 5'b00000) begin
            bad++;
            $display("FAIL fault_clear: got %b want 00000", {a_hi, a_lo, b_hi, b_lo, fault});
        end
        fault_clr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if ({a_hi, a_lo, b_hi, b_lo} !== ((i == 4) ? 4'b0110 : 4'b0000)) begin
                bad++;
                $display("FAIL reentry cycle %0d: gates %b want %b", i, {a_hi, a_lo, b_hi, b_lo},
                         (i == 4) ? 4'b0110 : 4'b0000);
            end
        end
    endtask

    task automatic test_async_reset();
        spwm_a = 1'b1;
        tick();
        tick();
        total++;
        if ({a_hi, a_lo, b_hi, b_lo} !== 4'b0010) begin
            bad++;
            $display("FAIL pre_reset: gates %b want 0010", {a_hi, a_lo, b_hi, b_lo});
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({a_hi, a_lo, b_hi, b_lo, fault, active} !== 6'b0) begin
            bad++;
            $display("FAIL async_reset: got %b want 000000", {a_hi, a_lo, b_hi, b_lo, fault, active});
        end
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if ({a_hi, a_lo, b_hi, b_lo} !== ((i == 4) ? 4'b1010 : 4'b0000)) begin
                bad++;
                $display("FAIL restart cycle %0d: gates %b want %b", i, {a_hi, a_lo, b_hi, b_lo},
                         (i == 4) ? 4'b1010 : 4'b0000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_fall();
        test_min_dead();
        test_glitch();
        test_fault();
        test_fault_clr();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
